// File: rtl/toggle_sync_multi_if.sv
// ---------------------------------------------------------------------------
// toggle_sync_multi_if
//   Bundles the event-line inputs, the per-channel status outputs and the
//   pending-event valid/ready port of toggle_sync_multi.
//
//   Parameters must match the attached toggle_sync_multi instance.
//     N_CH   number of channels
//     CNT_W  event counter width per channel
//     CH_W   width of evt_chan (derived from N_CH)
//
//   Signals
//     async_in   N_CH        asynchronous event lines, one per channel
//     cnt_clear  1           synchronous clear of counters and overflow flags
//     pulse_out  N_CH        1-cycle pulse per detected event
//     evt_valid  1           at least one channel pending
//     evt_chan   CH_W        lowest-index pending channel
//     evt_ready  1           consumer accepts evt_chan this cycle
//     count_out  N_CH*CNT_W  per-channel counters, channel k at [k*CNT_W +: CNT_W]
//     overflow   N_CH        sticky per-channel overflow flags
//
//   Modports
//     master  event source / consumer side
//     slave   synchroniser side (toggle_sync_multi)
// ---------------------------------------------------------------------------
interface toggle_sync_multi_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int CH_W  = ($clog2(N_CH) > 0) ? $clog2(N_CH) : 1
);

    logic [N_CH-1:0]       async_in;
    logic                  cnt_clear;
    logic [N_CH-1:0]       pulse_out;
    logic                  evt_valid;
    logic [CH_W-1:0]       evt_chan;
    logic                  evt_ready;
    logic [N_CH*CNT_W-1:0] count_out;
    logic [N_CH-1:0]       overflow;

    modport master (
        output async_in,
        output cnt_clear,
        output evt_ready,
        input  pulse_out,
        input  evt_valid,
        input  evt_chan,
        input  count_out,
        input  overflow
    );

    modport slave (
        input  async_in,
        input  cnt_clear,
        input  evt_ready,
        output pulse_out,
        output evt_valid,
        output evt_chan,
        output count_out,
        output overflow
    );

endinterface

// File: rtl/toggle_sync_multi.sv
// ---------------------------------------------------------------------------
// toggle_sync_multi
//   N-channel synchroniser for asynchronous toggle/level event lines coming
//   from foreign clock domains. Per channel: a SYNC_STAGES flop chain, a
//   mode-selectable edge detector, a 1-cycle pulse, a saturating event
//   counter and a sticky overflow flag. Detected events are also queued as
//   pending bits that a consumer drains over a valid/ready port, lowest
//   channel first.
//
//   After every reset the block spends SYNC_STAGES+1 cycles in ARMING, during
//   which detected edges are dropped, so a line that is already high when
//   reset is released never reports a spurious event.
//
//   Parameters
//     N_CH         number of channels, 1..32
//     SYNC_STAGES  synchroniser flops per channel, 2..8
//     EDGE_MODE    0 = any edge, 1 = rising only, 2 = falling only
//     CNT_W        event counter width, 1..32
//     CH_W         width of evt_chan (derived, leave at default)
//
//   Ports
//     clk      single clock, all logic on posedge
//     reset_n  synchronous active-low reset
//     bus      toggle_sync_multi_if.slave (async_in, cnt_clear, pulse_out,
//              evt_valid, evt_chan, evt_ready, count_out, overflow)
// ---------------------------------------------------------------------------
module toggle_sync_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 3,
    parameter int EDGE_MODE   = 0,
    parameter int CNT_W       = 16,
    parameter int CH_W        = ($clog2(N_CH) > 0) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    toggle_sync_multi_if.slave bus
);

    // Arm counter must be able to hold the value SYNC_STAGES.
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);

    localparam int EDGE_ANY  = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_ARMING = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ARM_W-1:0]   arm_cnt_r;
    logic [ARM_W-1:0]   arm_cnt_nxt_s;
    logic               run_s;

    // sync_r[i] holds stage i of every channel's chain.
    logic [N_CH-1:0]    sync_r [SYNC_STAGES];
    logic [N_CH-1:0]    edge_r;
    logic [N_CH-1:0]    sync_last_s;
    logic [N_CH-1:0]    event_s;
    logic [N_CH-1:0]    fire_s;

    logic [N_CH-1:0]    pulse_r;
    logic [N_CH-1:0]    pending_r;
    logic [N_CH-1:0]    pending_nxt_s;
    logic [N_CH-1:0]    overflow_r;
    logic [N_CH-1:0]    overflow_nxt_s;
    logic [CNT_W-1:0]   cnt_r     [N_CH];
    logic [CNT_W-1:0]   cnt_nxt_s [N_CH];

    logic               evt_valid_s;
    logic [CH_W-1:0]    evt_chan_s;
    logic               accept_s;
    logic [N_CH-1:0]    clr_s;
    logic [N_CH*CNT_W-1:0] count_flat_s;

    // FSM state and arm counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_ARMING;
            arm_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            arm_cnt_r <= arm_cnt_nxt_s;
        end
    end

    // FSM next state: ARMING lasts SYNC_STAGES+1 cycles, RUN holds until reset.
    always_comb begin
        state_nxt_s   = state_r;
        arm_cnt_nxt_s = arm_cnt_r;
        case (state_r)
            ST_ARMING: begin
                if (arm_cnt_r == ARM_W'(SYNC_STAGES)) begin
                    state_nxt_s   = ST_RUN;
                    arm_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s   = ST_ARMING;
                    arm_cnt_nxt_s = arm_cnt_r + ARM_W'(1);
                end
            end
            ST_RUN: begin
                state_nxt_s   = ST_RUN;
                arm_cnt_nxt_s = arm_cnt_r;
            end
            default: begin
                state_nxt_s   = ST_ARMING;
                arm_cnt_nxt_s = '0;
            end
        endcase
    end

    assign run_s = (state_r == ST_RUN);

    // Synchroniser chains plus the delayed copy used by the edge detector.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
            edge_r <= '0;
        end else begin
            sync_r[0] <= bus.async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detection; events are only honoured once the block is in RUN.
    always_comb begin
        sync_last_s = sync_r[SYNC_STAGES-1];
        event_s     = '0;
        case (EDGE_MODE)
            EDGE_ANY:  event_s = sync_last_s ^ edge_r;
            EDGE_RISE: event_s = sync_last_s & ~edge_r;
            EDGE_FALL: event_s = ~sync_last_s & edge_r;
            default:   event_s = sync_last_s ^ edge_r;
        endcase
        fire_s = event_s & {N_CH{run_s}};
    end

    // Lowest-index pending channel; scanning downwards lets the lowest win.
    always_comb begin
        evt_chan_s = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (pending_r[k]) begin
                evt_chan_s = CH_W'(k);
            end else begin
                evt_chan_s = evt_chan_s;
            end
        end
    end

    assign evt_valid_s = |pending_r;
    assign accept_s    = evt_valid_s & bus.evt_ready;

    // Per-channel next values for pending, overflow and counters.
    // A channel being drained this cycle may take a new event without
    // overflowing; cnt_clear keeps only what this cycle's event contributes.
    always_comb begin
        clr_s          = '0;
        pending_nxt_s  = pending_r;
        overflow_nxt_s = overflow_r;
        for (int k = 0; k < N_CH; k++) begin
            cnt_nxt_s[k] = cnt_r[k];
        end
        for (int k = 0; k < N_CH; k++) begin
            clr_s[k]         = accept_s && (evt_chan_s == CH_W'(k));
            pending_nxt_s[k] = (pending_r[k] & ~clr_s[k]) | fire_s[k];
            if (bus.cnt_clear) begin
                overflow_nxt_s[k] = fire_s[k] & pending_r[k] & ~clr_s[k];
            end else begin
                overflow_nxt_s[k] = overflow_r[k] | (fire_s[k] & pending_r[k] & ~clr_s[k]);
            end
            if (bus.cnt_clear) begin
                cnt_nxt_s[k] = fire_s[k] ? CNT_ONE : '0;
            end else if (fire_s[k] && (cnt_r[k] != CNT_MAX)) begin
                cnt_nxt_s[k] = cnt_r[k] + CNT_ONE;
            end else begin
                cnt_nxt_s[k] = cnt_r[k];
            end
        end
    end

    // Pulse, pending, overflow and counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pulse_r    <= '0;
            pending_r  <= '0;
            overflow_r <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            pulse_r    <= fire_s;
            pending_r  <= pending_nxt_s;
            overflow_r <= overflow_nxt_s;
            for (int k = 0; k < N_CH; k++) begin
                cnt_r[k] <= cnt_nxt_s[k];
            end
        end
    end

    // Flatten the counter array onto the count_out bus.
    always_comb begin
        count_flat_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            count_flat_s[k*CNT_W +: CNT_W] = cnt_r[k];
        end
    end

    assign bus.pulse_out = pulse_r;
    assign bus.evt_valid = evt_valid_s;
    assign bus.evt_chan  = evt_chan_s;
    assign bus.overflow  = overflow_r;
    assign bus.count_out = count_flat_s;

endmodule

// File: tb/tb_toggle_sync_multi.sv
// ---------------------------------------------------------------------------
// tb_toggle_sync_multi
//   Directed bench for toggle_sync_multi. Four instances share clock, reset
//   and stimulus: default parameters, CNT_W=2, EDGE_MODE=1 and EDGE_MODE=2.
//   Inputs change and outputs are sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_toggle_sync_multi;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] async_in_r;
    logic       cnt_clear_r;
    logic       evt_ready_r;

    int check_cnt = 0;
    int err_cnt   = 0;

    always #5 clk = ~clk;

    toggle_sync_multi_if #(.N_CH(4), .CNT_W(16), .CH_W(2)) if_def  ();
    toggle_sync_multi_if #(.N_CH(4), .CNT_W(2),  .CH_W(2)) if_sat  ();
    toggle_sync_multi_if #(.N_CH(4), .CNT_W(16), .CH_W(2)) if_rise ();
    toggle_sync_multi_if #(.N_CH(4), .CNT_W(16), .CH_W(2)) if_fall ();

    assign if_def.async_in   = async_in_r;
    assign if_def.cnt_clear  = cnt_clear_r;
    assign if_def.evt_ready  = evt_ready_r;
    assign if_sat.async_in   = async_in_r;
    assign if_sat.cnt_clear  = cnt_clear_r;
    assign if_sat.evt_ready  = evt_ready_r;
    assign if_rise.async_in  = async_in_r;
    assign if_rise.cnt_clear = cnt_clear_r;
    assign if_rise.evt_ready = evt_ready_r;
    assign if_fall.async_in  = async_in_r;
    assign if_fall.cnt_clear = cnt_clear_r;
    assign if_fall.evt_ready = evt_ready_r;

    toggle_sync_multi #(.N_CH(4), .SYNC_STAGES(S), .EDGE_MODE(0), .CNT_W(16)) u_dut_def (
        .clk(clk), .reset_n(reset_n), .bus(if_def.slave));
    toggle_sync_multi #(.N_CH(4), .SYNC_STAGES(S), .EDGE_MODE(0), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(if_sat.slave));
    toggle_sync_multi #(.N_CH(4), .SYNC_STAGES(S), .EDGE_MODE(1), .CNT_W(16)) u_dut_rise (
        .clk(clk), .reset_n(reset_n), .bus(if_rise.slave));
    toggle_sync_multi #(.N_CH(4), .SYNC_STAGES(S), .EDGE_MODE(2), .CNT_W(16)) u_dut_fall (
        .clk(clk), .reset_n(reset_n), .bus(if_fall.slave));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with the given line levels, then wait out the arming window.
    task automatic do_reset(input logic [3:0] lines);
        async_in_r = lines;
        reset_n    = 1'b0;
        tick(2);
        reset_n    = 1'b1;
        tick(S + 1);
    endtask

    initial begin
        reset_n     = 1'b0;
        async_in_r  = 4'b0000;
        cnt_clear_r = 1'b0;
        evt_ready_r = 1'b1;
        tick(2);
        check_val("rst_pulse",    64'(if_def.pulse_out), 64'h0);
        check_val("rst_valid",    64'(if_def.evt_valid), 64'h0);
        check_val("rst_chan",     64'(if_def.evt_chan),  64'h0);
        check_val("rst_count",    64'(if_def.count_out), 64'h0);
        check_val("rst_overflow", 64'(if_def.overflow),  64'h0);
        reset_n = 1'b1;
        tick(S + 1);

        // T1: single rising edge on ch0 with the consumer always ready.
        async_in_r = 4'b0001;
        tick(S);
        check_val("t1_pulse_early", 64'(if_def.pulse_out), 64'h0);
        tick(1);
        check_val("t1_pulse",  64'(if_def.pulse_out), 64'h1);
        check_val("t1_count",  64'(if_def.count_out), 64'h1);
        check_val("t1_valid",  64'(if_def.evt_valid), 64'h1);
        check_val("t1_chan",   64'(if_def.evt_chan),  64'h0);
        tick(1);
        check_val("t1_pulse_end", 64'(if_def.pulse_out), 64'h0);
        check_val("t1_drained",   64'(if_def.evt_valid), 64'h0);

        // T2: lines held high through reset must not produce events.
        do_reset(4'b1111);
        check_val("t2_pulse", 64'(if_def.pulse_out), 64'h0);
        check_val("t2_count", 64'(if_def.count_out), 64'h0);
        check_val("t2_valid", 64'(if_def.evt_valid), 64'h0);
        tick(3);
        check_val("t2_pulse_late", 64'(if_def.pulse_out), 64'h0);
        check_val("t2_valid_late", 64'(if_def.evt_valid), 64'h0);
        async_in_r = 4'b1011;
        tick(S + 1);
        check_val("t2_pulse_ch2", 64'(if_def.pulse_out), 64'h4);
        check_val("t2_count_ch2", 64'(if_def.count_out), 64'h0000_0001_0000_0000);

        // T3: stalled consumer, events on ch3 then ch1, second ch1 event overflows.
        do_reset(4'b0000);
        evt_ready_r = 1'b0;
        async_in_r  = 4'b1000;
        tick(5);
        async_in_r  = 4'b1010;
        tick(5);
        check_val("t3_valid", 64'(if_def.evt_valid), 64'h1);
        check_val("t3_chan1", 64'(if_def.evt_chan),  64'h1);
        check_val("t3_no_ovf", 64'(if_def.overflow), 64'h0);
        tick(5);
        async_in_r  = 4'b1000;
        tick(5);
        check_val("t3_overflow", 64'(if_def.overflow),  64'h2);
        check_val("t3_counts",   64'(if_def.count_out), 64'h0001_0000_0002_0000);
        check_val("t3_chan_hold", 64'(if_def.evt_chan), 64'h1);
        evt_ready_r = 1'b1;
        tick(1);
        check_val("t3_chan3",  64'(if_def.evt_chan),  64'h3);
        check_val("t3_valid2", 64'(if_def.evt_valid), 64'h1);
        tick(1);
        check_val("t3_empty",    64'(if_def.evt_valid), 64'h0);
        check_val("t3_ovf_sticky", 64'(if_def.overflow), 64'h2);

        // T4: 2-bit counter saturation, then cnt_clear coinciding with an event.
        do_reset(4'b0000);
        evt_ready_r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            async_in_r[0] = ~async_in_r[0];
            tick(5);
        end
        check_val("t4_saturate", 64'(if_sat.count_out), 64'h3);
        check_val("t4_overflow", 64'(if_sat.overflow),  64'h1);
        check_val("t4_def_count", 64'(if_def.count_out), 64'h5);
        evt_ready_r = 1'b1;
        tick(2);
        check_val("t4_drained", 64'(if_sat.evt_valid), 64'h0);
        async_in_r[0] = ~async_in_r[0];
        tick(S);
        cnt_clear_r = 1'b1;
        tick(1);
        cnt_clear_r = 1'b0;
        check_val("t4_clr_pulse", 64'(if_sat.pulse_out), 64'h1);
        check_val("t4_clr_count", 64'(if_sat.count_out), 64'h1);
        check_val("t4_clr_ovf",   64'(if_sat.overflow),  64'h0);
        check_val("t4_clr_def",   64'(if_def.count_out), 64'h1);

        // T5: 0->1->0->1 on ch2 seen by any/rising/falling detectors.
        do_reset(4'b0000);
        async_in_r = 4'b0100;
        tick(6);
        async_in_r = 4'b0000;
        tick(6);
        async_in_r = 4'b0100;
        tick(6);
        check_val("t5_any",  64'(if_def.count_out),  64'h0000_0003_0000_0000);
        check_val("t5_rise", 64'(if_rise.count_out), 64'h0000_0002_0000_0000);
        check_val("t5_fall", 64'(if_fall.count_out), 64'h0000_0001_0000_0000);

        // T6: one-cycle reset with two channels pending.
        do_reset(4'b0000);
        evt_ready_r = 1'b0;
        async_in_r  = 4'b0011;
        tick(5);
        check_val("t6_pre_valid", 64'(if_def.evt_valid), 64'h1);
        check_val("t6_pre_chan",  64'(if_def.evt_chan),  64'h0);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check_val("t6_pulse",    64'(if_def.pulse_out), 64'h0);
        check_val("t6_valid",    64'(if_def.evt_valid), 64'h0);
        check_val("t6_chan",     64'(if_def.evt_chan),  64'h0);
        check_val("t6_count",    64'(if_def.count_out), 64'h0);
        check_val("t6_overflow", 64'(if_def.overflow),  64'h0);
        for (int i = 0; i < S + 1; i++) begin
            tick(1);
            check_val("t6_arm_pulse", 64'(if_def.pulse_out), 64'h0);
        end
        tick(3);
        check_val("t6_arm_count", 64'(if_def.count_out), 64'h0);
        check_val("t6_arm_valid", 64'(if_def.evt_valid), 64'h0);
        async_in_r = 4'b0010;
        tick(S + 1);
        check_val("t6_run_pulse", 64'(if_def.pulse_out), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
